input_debouncer: RTL and testbench

- Per-bit debouncer and edge detector for mechanical or noisy inputs (buttons, switches, jumpers).
- Sits directly downstream of the two-flop CDC synchronizer: its input is the synchronizer's q_o, already in the clk_i domain.
- Emits a filtered level per bit plus single-cycle rise and fall strobes for control FSMs.
- Optional tick_i prescale lets long debounce windows use small counters.

---
 rtl/input_debouncer_pkg.sv | 7 +
 rtl/input_debouncer_ch.sv | 60 ++++++
 rtl/input_debouncer.sv | 42 ++++
 tb/tb_input_debouncer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared sizing helper for the debouncer slice.
package input_debouncer_pkg;
  // Counter must hold 0..ticks-1; a zero-width counter is never allowed.
  function automatic int cnt_w(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction
endpackage

// File: rtl/input_debouncer_ch.sv
// Single-bit debounce channel: stability counter, accepted level, edge strobes.
module input_debouncer_ch
  import input_debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = 4,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sync_i,
  input  logic tick_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);
  localparam int            CW   = cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_level, r_rise, r_fall, r_busy;
  logic          w_accept;

  // Any sample agreeing with the current level restarts the window.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_accept  = 1'b0;
    if (sync_i == r_level) begin
      w_cnt_nxt = '0;
    end else if (tick_i) begin
      if (r_cnt == LAST) begin
        w_accept  = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_level <= RESET_LEVEL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= |w_cnt_nxt;
      r_rise <= w_accept & sync_i;
      r_fall <= w_accept & ~sync_i;
      if (w_accept) r_level <= sync_i;
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
  assign busy_o  = r_busy;
endmodule

// File: rtl/input_debouncer.sv
// Per-bit debouncer / edge detector fed from an external two-flop synchronizer.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int   WIDTH        = 1,
  parameter int   STABLE_TICKS = 4,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] sync_i,
  input  logic             tick_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             busy_o
);
  logic [WIDTH-1:0] w_busy;

  if (STABLE_TICKS < 1) begin : g_bad_param
    $error("input_debouncer: STABLE_TICKS must be >= 1");
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_ch
    input_debouncer_ch #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .sync_i (sync_i[k]),
      .tick_i (tick_i),
      .level_o(level_o[k]),
      .rise_o (rise_o[k]),
      .fall_o (fall_o[k]),
      .busy_o (w_busy[k])
    );
  end

  // Each channel's busy bit is already registered from its post-edge count.
  assign busy_o = |w_busy;
endmodule

// File: tb/tb_input_debouncer.sv
// Bench: three debouncer configurations on shared stimulus, checked against a
// tick-run reference model plus a hand-derived vector table and reset sequences.
module tb_input_debouncer;
  logic       clk, rst_n, tick;
  logic [1:0] sync;
  logic [1:0] lvl[3], rise[3], fall[3];
  logic       busy[3];

  int total = 0, bad = 0;

  // Configurations: {STABLE_TICKS, RESET_LEVEL}
  int P_ST[3] = '{4, 4, 1};
  int P_RL[3] = '{0, 1, 0};

  input_debouncer #(.WIDTH(2), .STABLE_TICKS(4), .RESET_LEVEL(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .sync_i(sync), .tick_i(tick),
    .level_o(lvl[0]), .rise_o(rise[0]), .fall_o(fall[0]), .busy_o(busy[0]));
  input_debouncer #(.WIDTH(2), .STABLE_TICKS(4), .RESET_LEVEL(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .sync_i(sync), .tick_i(tick),
    .level_o(lvl[1]), .rise_o(rise[1]), .fall_o(fall[1]), .busy_o(busy[1]));
  input_debouncer #(.WIDTH(2), .STABLE_TICKS(1), .RESET_LEVEL(1'b0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .sync_i(sync), .tick_i(tick),
    .level_o(lvl[2]), .rise_o(rise[2]), .fall_o(fall[2]), .busy_o(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: count qualifying ticks since the input last agreed with the level.
  int   m_run[3][2];
  logic m_lvl[3][2], m_r[3][2], m_f[3][2];

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 2; k++) begin
        m_run[d][k] = 0;
        m_lvl[d][k] = (P_RL[d] != 0);
        m_r[d][k]   = 1'b0;
        m_f[d][k]   = 1'b0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 2; k++) begin
        m_r[d][k] = 1'b0;
        m_f[d][k] = 1'b0;
        if (sync[k] == m_lvl[d][k]) m_run[d][k] = 0;
        else if (tick) begin
          m_run[d][k] = m_run[d][k] + 1;
          if (m_run[d][k] == P_ST[d]) begin
            m_lvl[d][k] = sync[k];
            m_r[d][k]   = sync[k];
            m_f[d][k]   = ~sync[k];
            m_run[d][k] = 0;
          end
        end
      end
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0] el, er, ef;
    logic       eb;
    for (int d = 0; d < 3; d++) begin
      eb = 1'b0;
      for (int k = 0; k < 2; k++) begin
        el[k] = m_lvl[d][k];
        er[k] = m_r[d][k];
        ef[k] = m_f[d][k];
        if (m_run[d][k] != 0) eb = 1'b1;
      end
      chk($sformatf("model_level%0d", d), lvl[d], el);
      chk($sformatf("model_rise%0d", d), rise[d], er);
      chk($sformatf("model_fall%0d", d), fall[d], ef);
      chk($sformatf("model_busy%0d", d), {1'b0, busy[d]}, {1'b0, eb});
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
  endtask

  typedef struct {
    logic [1:0] sync;
    logic       tick;
    logic [1:0] lvl, rise, fall;
    logic       busy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] s, input logic t, input logic [1:0] l,
                     input logic [1:0] r, input logic [1:0] f, input logic b);
    vec_t v;
    v.sync = s; v.tick = t; v.lvl = l; v.rise = r; v.fall = f; v.busy = b;
    tbl.push_back(v);
  endtask

  initial begin
    // Clean rise on bit 0
    add(2'b01,1,2'b00,2'b00,2'b00,1); add(2'b01,1,2'b00,2'b00,2'b00,1);
    add(2'b01,1,2'b00,2'b00,2'b00,1); add(2'b01,1,2'b01,2'b01,2'b00,0);
    add(2'b01,1,2'b01,2'b00,2'b00,0);
    // Simultaneous opposite changes on both bits
    add(2'b10,1,2'b01,2'b00,2'b00,1); add(2'b10,1,2'b01,2'b00,2'b00,1);
    add(2'b10,1,2'b01,2'b00,2'b00,1); add(2'b10,1,2'b10,2'b10,2'b01,0);
    add(2'b10,1,2'b10,2'b00,2'b00,0);
    // Bounce: three highs, one low, then a full run of four
    add(2'b11,1,2'b10,2'b00,2'b00,1); add(2'b11,1,2'b10,2'b00,2'b00,1);
    add(2'b11,1,2'b10,2'b00,2'b00,1); add(2'b10,1,2'b10,2'b00,2'b00,0);
    add(2'b11,1,2'b10,2'b00,2'b00,1); add(2'b11,1,2'b10,2'b00,2'b00,1);
    add(2'b11,1,2'b10,2'b00,2'b00,1); add(2'b11,1,2'b11,2'b01,2'b00,0);
    // Prescale: tick every third cycle, bit 0 falls on the fourth tick
    add(2'b10,0,2'b11,2'b00,2'b00,0); add(2'b10,0,2'b11,2'b00,2'b00,0);
    add(2'b10,1,2'b11,2'b00,2'b00,1); add(2'b10,0,2'b11,2'b00,2'b00,1);
    add(2'b10,0,2'b11,2'b00,2'b00,1); add(2'b10,1,2'b11,2'b00,2'b00,1);
    add(2'b10,0,2'b11,2'b00,2'b00,1); add(2'b10,0,2'b11,2'b00,2'b00,1);
    add(2'b10,1,2'b11,2'b00,2'b00,1); add(2'b10,0,2'b11,2'b00,2'b00,1);
    add(2'b10,0,2'b11,2'b00,2'b00,1); add(2'b10,1,2'b10,2'b00,2'b01,0);

    // Reset state
    rst_n = 1'b0; sync = 2'b00; tick = 1'b1;
    model_reset();
    #12;
    chk("rst_level0", lvl[0], 2'b00);
    chk("rst_level1", lvl[1], 2'b11);
    chk("rst_strobes0", rise[0] | fall[0], 2'b00);
    chk("rst_busy0", {1'b0, busy[0]}, 2'b00);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    chk("post_rst_level0", lvl[0], 2'b00);

    // Vector table against dut0 (STABLE_TICKS=4, RESET_LEVEL=0)
    foreach (tbl[i]) begin
      sync = tbl[i].sync; tick = tbl[i].tick;
      step();
      chk($sformatf("tbl%0d_level", i), lvl[0], tbl[i].lvl);
      chk($sformatf("tbl%0d_rise", i), rise[0], tbl[i].rise);
      chk($sformatf("tbl%0d_fall", i), fall[0], tbl[i].fall);
      chk($sformatf("tbl%0d_busy", i), {1'b0, busy[0]}, {1'b0, tbl[i].busy});
    end

    // Reset mid-count on the RESET_LEVEL=1 instance
    rst_n = 1'b0; sync = 2'b00; tick = 1'b1;
    model_reset();
    #1;
    rst_n = 1'b1;
    step(); step();
    chk("midcnt_busy1_before", {1'b0, busy[1]}, 2'b01);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_level1", lvl[1], 2'b11);
    chk("midrst_busy1", {1'b0, busy[1]}, 2'b00);
    check_all();
    sync = 2'b11;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel_same_nostrobe1", rise[1] | fall[1], 2'b00);
    end
    sync = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rel_diff_wait_fall1", fall[1], 2'b00);
      chk("rel_diff_wait_level1", lvl[1], 2'b11);
    end
    step();
    chk("rel_diff_fall1", fall[1], 2'b11);
    chk("rel_diff_level1", lvl[1], 2'b00);
    chk("rel_diff_rise1", rise[1], 2'b00);

    // Randomized run with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        rst_n = 1'b1;
      end
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 5) == 0) sync[k] = ~sync[k];
      tick = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
